// File: rtl/clk_divider.sv
// clk_divider: free-running divider producing single-cycle clock-enable strobes
// for the display serializer, time-set rate and 1 Hz timekeeping.
module clk_divider_stage #(
    parameter int unsigned DIV = 2
) (
    input  logic clk,
    input  logic rst_n,
    output logic strobe_o
);
    localparam int unsigned W = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [W-1:0] LAST = W'(DIV - 1);

    logic [W-1:0] cnt_q, cnt_d;
    logic         stb_q, stb_d;

    // Wrap and strobe share one edge so the period is exactly DIV cycles.
    always_comb begin
        stb_d = (cnt_q == LAST);
        cnt_d = stb_d ? '0 : cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            stb_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            stb_q <= stb_d;
        end
    end

    assign strobe_o = stb_q;
endmodule

module clk_divider #(
    parameter int unsigned CLK_HZ  = 12500,
    parameter int unsigned SR_DIV  = 5,
    parameter int unsigned SET_DIV = 2500
) (
    input  logic clk,
    input  logic rst_n,
    output logic clk_sr,
    output logic clk_set,
    output logic clk_1hz
);
    clk_divider_stage #(.DIV(SR_DIV))  u_sr  (.clk(clk), .rst_n(rst_n), .strobe_o(clk_sr));
    clk_divider_stage #(.DIV(SET_DIV)) u_set (.clk(clk), .rst_n(rst_n), .strobe_o(clk_set));
    clk_divider_stage #(.DIV(CLK_HZ))  u_sec (.clk(clk), .rst_n(rst_n), .strobe_o(clk_1hz));
endmodule

// File: tb/tb_clk_divider.sv
// tb_clk_divider: scoreboard bench comparing default and small-parameter
// dividers against an edge-count reference model.
module tb_clk_divider;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic sr_a, set_a, hz_a, sr_b, set_b, hz_b;

    always #5 clk = ~clk;

    clk_divider dut_a (.clk(clk), .rst_n(rst_n), .clk_sr(sr_a), .clk_set(set_a), .clk_1hz(hz_a));
    clk_divider #(.CLK_HZ(8), .SR_DIV(2), .SET_DIV(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .clk_sr(sr_b), .clk_set(set_b), .clk_1hz(hz_b));

    logic [5:0] exp_q[$];
    logic [5:0] exp_v;
    logic [5:0] got_async;
    logic       async_pending = 1'b0;
    int         n = 0;
    int         checks = 0;
    int         fails = 0;
    int         cyc = 0;

    function automatic logic hit(int k, int d);
        return k > 0 && k % d == 0;
    endfunction

    // Model: a strobe of divisor d is high in the cycle after edges d, 2d, ...
    task automatic tick();
        @(posedge clk);
        n = rst_n ? n + 1 : 0;
        exp_q.push_back({hit(n, 2), hit(n, 4), hit(n, 8), hit(n, 5), hit(n, 2500), hit(n, 12500)});
    endtask

    always @(negedge clk) begin
        cyc++;
        if (exp_q.size() > 0) begin
            exp_v = exp_q.pop_front();
            checks++;
            if ({sr_b, set_b, hz_b, sr_a, set_a, hz_a} !== exp_v) begin
                fails++;
                $display("FAIL strobes cyc=%0d n=%0d got=%b exp=%b", cyc, n,
                         {sr_b, set_b, hz_b, sr_a, set_a, hz_a}, exp_v);
            end
        end
        if (async_pending) begin
            async_pending = 1'b0;
            checks++;
            if (got_async !== 6'b0) begin
                fails++;
                $display("FAIL async_reset got=%b exp=%b", got_async, 6'b0);
            end
        end
    end

    initial begin
        repeat (10) tick();
        @(negedge clk); #2 rst_n = 1'b1;
        repeat (50000) tick();
        @(negedge clk); #2 rst_n = 1'b0;
        repeat (3) tick();
        @(negedge clk); #2 rst_n = 1'b1;
        repeat (7000) tick();
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 got_async = {sr_b, set_b, hz_b, sr_a, set_a, hz_a};
        async_pending = 1'b1;
        #1 rst_n = 1'b1;
        n = 0;
        repeat ($urandom_range(12510, 12600)) tick();
        @(negedge clk);
        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
